nasti_init_master: RTL and testbench

NASTI_INIT_MASTER -- requirements
Module: nasti_init_master

---
 rtl/nasti_init_master.sv | 220 ++++++++++++++++++++++
 tb/tb_nasti_init_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_init_master.sv
// rtl/nasti_init_master.sv - single-outstanding AXI burst master bridging a command port to AW/W/B/AR/R
// Write data and read data pass straight through combinationally; only addr/len/beat/resp are stored.
module nasti_init_master #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int C_TXN_ID           = 0
) (
    input  logic                            core_clk_i,
    input  logic                            core_rst_i,

    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]                      cmd_len_i,

    input  logic                            wd_valid_i,
    output logic                            wd_ready_o,
    input  logic [C_NASTI_DATA_WIDTH-1:0]   wd_data_i,
    input  logic [C_NASTI_DATA_WIDTH/8-1:0] wd_strb_i,

    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [C_NASTI_DATA_WIDTH-1:0]   rd_data_o,
    output logic                            rd_last_o,

    output logic                            rsp_valid_o,
    output logic [1:0]                      rsp_resp_o,
    output logic                            proto_err_o,

    output logic                            m_awvalid_o,
    input  logic                            m_awready_i,
    output logic [C_NASTI_ID_WIDTH-1:0]     m_awid_o,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [7:0]                      m_awlen_o,
    output logic [2:0]                      m_awsize_o,
    output logic [1:0]                      m_awburst_o,

    output logic                            m_wvalid_o,
    input  logic                            m_wready_i,
    output logic [C_NASTI_DATA_WIDTH-1:0]   m_wdata_o,
    output logic [C_NASTI_DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                            m_wlast_o,

    input  logic                            m_bvalid_i,
    output logic                            m_bready_o,
    input  logic [1:0]                      m_bresp_i,

    output logic                            m_arvalid_o,
    input  logic                            m_arready_i,
    output logic [C_NASTI_ID_WIDTH-1:0]     m_arid_o,
    output logic [C_NASTI_ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [7:0]                      m_arlen_o,
    output logic [2:0]                      m_arsize_o,
    output logic [1:0]                      m_arburst_o,

    input  logic                            m_rvalid_i,
    output logic                            m_rready_o,
    input  logic [C_NASTI_DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]                      m_rresp_i,
    input  logic                            m_rlast_i
);

    localparam logic [C_NASTI_ID_WIDTH-1:0] TXN_ID = C_NASTI_ID_WIDTH'(C_TXN_ID);
    localparam logic [2:0] AXI_SIZE   = 3'($clog2(C_NASTI_DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                          state_q, state_d;
    logic [C_NASTI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [7:0]                      beat_q, beat_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            perr_q, perr_d;

    logic                            beat_last;
    logic [1:0]                      resp_acc;

    assign beat_last = (beat_q == len_q);
    // First non-OKAY response wins; later beats cannot overwrite it.
    assign resp_acc  = (resp_q == RESP_OKAY) ? m_rresp_i : resp_q;

    assign m_awid_o    = TXN_ID;
    assign m_awaddr_o  = addr_q;
    assign m_awlen_o   = len_q;
    assign m_awsize_o  = AXI_SIZE;
    assign m_awburst_o = BURST_INCR;
    assign m_arid_o    = TXN_ID;
    assign m_araddr_o  = addr_q;
    assign m_arlen_o   = len_q;
    assign m_arsize_o  = AXI_SIZE;
    assign m_arburst_o = BURST_INCR;
    assign m_wdata_o   = wd_data_i;
    assign m_wstrb_o   = wd_strb_i;
    assign rd_data_o   = m_rdata_i;
    assign proto_err_o = perr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        perr_d      = perr_q;
        cmd_ready_o = 1'b0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_wlast_o   = 1'b0;
        wd_ready_o  = 1'b0;
        m_bready_o  = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        rd_valid_o  = 1'b0;
        rd_last_o   = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_resp_o  = RESP_OKAY;

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    beat_d  = 8'd0;
                    resp_d  = RESP_OKAY;
                    state_d = cmd_write_i ? S_AW : S_AR;
                end
            end
            S_AW: begin
                m_awvalid_o = 1'b1;
                if (m_awready_i) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                m_wvalid_o = wd_valid_i;
                wd_ready_o = m_wready_i;
                m_wlast_o  = beat_last;
                if (wd_valid_i && m_wready_i) begin
                    if (beat_last) begin
                        beat_d  = 8'd0;
                        state_d = S_B;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                    end
                end
            end
            S_B: begin
                m_bready_o = 1'b1;
                if (m_bvalid_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_resp_o  = m_bresp_i;
                    state_d     = S_IDLE;
                end
            end
            S_AR: begin
                m_arvalid_o = 1'b1;
                if (m_arready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                m_rready_o = rd_ready_i;
                rd_valid_o = m_rvalid_i;
                rd_last_o  = m_rlast_i;
                if (m_rvalid_i && rd_ready_i) begin
                    // A slave whose RLAST disagrees with our beat count ends the burst early.
                    if (m_rlast_i != beat_last) begin
                        perr_d      = 1'b1;
                        rsp_valid_o = 1'b1;
                        rsp_resp_o  = RESP_SLV;
                        beat_d      = 8'd0;
                        state_d     = S_IDLE;
                    end else if (beat_last) begin
                        rsp_valid_o = 1'b1;
                        rsp_resp_o  = resp_acc;
                        beat_d      = 8'd0;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d      = beat_q + 8'd1;
                        resp_d      = resp_acc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk_i) begin
        if (core_rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            beat_q  <= 8'd0;
            resp_q  <= RESP_OKAY;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_nasti_init_master.sv
// tb/tb_nasti_init_master.sv - table-driven bench acting as command source, data sink/source and AXI slave
module tb_nasti_init_master;

    localparam int BUDGET = 5000;
    localparam int NV     = 11;

    logic         clk = 1'b0;
    logic         core_rst;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [31:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic         wd_valid, wd_ready;
    logic [63:0]  wd_data;
    logic [7:0]   wd_strb;
    logic         rd_valid, rd_ready, rd_last;
    logic [63:0]  rd_data;
    logic         rsp_valid, proto_err;
    logic [1:0]   rsp_resp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [8:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen, wstrb;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic [63:0]  wdata, rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cur_vec  = -1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] base;
        logic [7:0]  rr;
        int          bad_last;
        int          abort_beat;
        logic        stall;
        logic [1:0]  bresp;
        logic [1:0]  exp_resp;
        logic        exp_perr;
    } vec_t;

    vec_t vecs [NV];

    nasti_init_master #(
        .C_NASTI_ID_WIDTH  (9),
        .C_NASTI_ADDR_WIDTH(32),
        .C_NASTI_DATA_WIDTH(64),
        .C_TXN_ID          (5)
    ) dut (
        .core_clk_i (clk),
        .core_rst_i (core_rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_len_i  (cmd_len),
        .wd_valid_i (wd_valid),
        .wd_ready_o (wd_ready),
        .wd_data_i  (wd_data),
        .wd_strb_i  (wd_strb),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_last_o  (rd_last),
        .rsp_valid_o(rsp_valid),
        .rsp_resp_o (rsp_resp),
        .proto_err_o(proto_err),
        .m_awvalid_o(awvalid),
        .m_awready_i(awready),
        .m_awid_o   (awid),
        .m_awaddr_o (awaddr),
        .m_awlen_o  (awlen),
        .m_awsize_o (awsize),
        .m_awburst_o(awburst),
        .m_wvalid_o (wvalid),
        .m_wready_i (wready),
        .m_wdata_o  (wdata),
        .m_wstrb_o  (wstrb),
        .m_wlast_o  (wlast),
        .m_bvalid_i (bvalid),
        .m_bready_o (bready),
        .m_bresp_i  (bresp),
        .m_arvalid_o(arvalid),
        .m_arready_i(arready),
        .m_arid_o   (arid),
        .m_araddr_o (araddr),
        .m_arlen_o  (arlen),
        .m_arsize_o (arsize),
        .m_arburst_o(arburst),
        .m_rvalid_i (rvalid),
        .m_rready_o (rready),
        .m_rdata_i  (rdata),
        .m_rresp_i  (rresp),
        .m_rlast_i  (rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", cur_vec, name, act, exp);
        end
    endtask

    task automatic check_idle(input logic exp_perr);
        check("idle_outputs",
              {cmd_ready, rsp_valid, rsp_resp, awvalid, wvalid, wlast, arvalid, bready, rready, wd_ready, rd_valid},
              {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("proto_err", proto_err, exp_perr);
    endtask

    function automatic logic rbit(input logic stall);
        return stall ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic run_vec(input vec_t v);
        int       i;
        int       cyc;
        int       exp_beats;
        logic     done;
        logic     lst;
        logic     term;
        logic [7:0] rr;

        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        #1;
        check("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < BUDGET) begin
            if (v.wr) awready = rbit(v.stall); else arready = rbit(v.stall);
            #1;
            if (v.wr) begin
                check("aw_valid", {awvalid, arvalid}, 2'b10);
                check("aw_fields", {awaddr, awlen, awsize, awburst, awid}, {v.addr, v.len, 3'd3, 2'b01, 9'd5});
                done = awready;
            end else begin
                check("ar_valid", {arvalid, awvalid}, 2'b10);
                check("ar_fields", {araddr, arlen, arsize, arburst, arid}, {v.addr, v.len, 3'd3, 2'b01, 9'd5});
                done = arready;
            end
            @(posedge clk); #1;
            cyc++;
        end
        awready = 1'b0;
        arready = 1'b0;
        check("addr_handshake", done, 1'b1);

        i    = 0;
        done = 1'b0;
        cyc  = 0;
        if (v.wr) begin
            while (!done && cyc < BUDGET) begin
                wd_valid = rbit(v.stall);
                wready   = rbit(v.stall);
                wd_data  = v.base + 64'(i);
                wd_strb  = 8'(i) ^ 8'hF0;
                if (i == v.abort_beat) begin
                    wd_valid = 1'b1;
                    wready   = 1'b1;
                    core_rst = 1'b1;
                    @(posedge clk); #1;
                    core_rst = 1'b0;
                    wd_valid = 1'b0;
                    wready   = 1'b0;
                    #1;
                    check("abort_outputs",
                          {awvalid, wvalid, arvalid, bready, rready, wd_ready, rd_valid, rsp_valid, cmd_ready, proto_err},
                          10'b00000000_10);
                    return;
                end
                #1;
                check("w_handshake", {wvalid, wd_ready}, {wd_valid, wready});
                check("w_payload", {wdata, wstrb}, {v.base + 64'(i), 8'(i) ^ 8'hF0});
                check("wlast", wlast, (i == int'(v.len)));
                check("w_rsp_quiet", rsp_valid, 1'b0);
                if (wd_valid && wready) begin
                    if (i == int'(v.len)) done = 1'b1;
                    i++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            wd_valid = 1'b0;
            wready   = 1'b0;
            check("w_beats", i, int'(v.len) + 1);

            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < BUDGET) begin
                bvalid = v.stall ? 1'($urandom_range(0, 1)) : (cyc > 0);
                bresp  = v.bresp;
                #1;
                check("bready", bready, 1'b1);
                check("rsp_b", {rsp_valid, rsp_resp}, bvalid ? {1'b1, v.exp_resp} : 3'b000);
                done = bvalid;
                @(posedge clk); #1;
                cyc++;
            end
            bvalid = 1'b0;
            check("b_handshake", done, 1'b1);
        end else begin
            rr = v.rr;
            while (!done && cyc < BUDGET) begin
                rvalid   = rbit(v.stall);
                rd_ready = rbit(v.stall);
                rdata    = v.base + 64'(i);
                rresp    = (i < 4) ? 2'(rr >> (2 * i)) : 2'b00;
                lst      = (v.bad_last >= 0) ? (i == v.bad_last) : (i == int'(v.len));
                rlast    = lst;
                #1;
                check("r_handshake", {rd_valid, rready}, {rvalid, rd_ready});
                check("r_payload", {rd_data, rd_last}, {v.base + 64'(i), lst});
                term = rvalid && rd_ready && (lst || i == int'(v.len));
                check("rsp_r", {rsp_valid, rsp_resp}, term ? {1'b1, v.exp_resp} : 3'b000);
                if (rvalid && rd_ready) begin
                    i++;
                    done = term;
                end
                @(posedge clk); #1;
                cyc++;
            end
            rvalid   = 1'b0;
            rd_ready = 1'b0;
            rlast    = 1'b0;
            exp_beats = (v.bad_last >= 0 && v.bad_last < int'(v.len)) ? v.bad_last + 1 : int'(v.len) + 1;
            check("r_beats", i, exp_beats);
        end
        #1;
        check_idle(v.exp_perr);
    endtask

    initial begin
        core_rst  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        wd_strb   = '0;
        rd_ready  = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;

        //            wr    addr          len     base                     rr     bad ab  st    bresp  exp    perr
        vecs[0]  = '{1'b1, 32'h0000_0100, 8'd3,   64'd1,                   8'h00, -1, -1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0200, 8'd0,   64'hDEAD,                8'h00, -1, -1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0300, 8'd3,   64'h30,                  8'h38, -1, -1, 1'b0, 2'b00, 2'b10, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0400, 8'd0,   64'h77,                  8'h00, -1, -1, 1'b0, 2'b11, 2'b11, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0500, 8'd3,   64'h50,                  8'h00,  1, -1, 1'b0, 2'b00, 2'b10, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0600, 8'd1,   64'h60,                  8'h00, -1, -1, 1'b0, 2'b00, 2'b00, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0700, 8'd2,   64'h70,                  8'h00,  7, -1, 1'b0, 2'b00, 2'b10, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_1000, 8'd255, 64'hA5A5_0000_0000_0000, 8'h00, -1, -1, 1'b1, 2'b00, 2'b00, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_2000, 8'd255, 64'h5A5A_0000_0000_0000, 8'h00, -1, -1, 1'b1, 2'b01, 2'b01, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_3000, 8'd7,   64'h90,                  8'h00, -1,  4, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_4000, 8'd1,   64'hB0,                  8'h01, -1, -1, 1'b0, 2'b00, 2'b01, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_idle(1'b0);
        core_rst = 1'b0;
        #1;
        check_idle(1'b0);

        for (int k = 0; k < NV; k++) begin
            cur_vec = k;
            run_vec(vecs[k]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
